// File: rtl/pagerank_pkg.sv
// Shared types and defaults for the PageRank result collector slice.
package pagerank_pkg;

    localparam int NBITS      = 32;
    localparam int NWORKERS   = 2;
    localparam int NNODES     = 8;
    localparam int NODE_IDX_W = $clog2(NNODES);

    typedef logic [NBITS-1:0]      rank_t;
    typedef logic [NODE_IDX_W-1:0] node_idx_t;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } collect_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pagerank_result_collector_if.sv
// Worker-result and scheduler-output bundle of the result collector.
// master = collector side, slave = workers/scheduler side.
interface pagerank_result_collector_if #(
    parameter int nbits    = 32,
    parameter int nworkers = 2,
    parameter int nnodes   = 8
);
    localparam int iw = $clog2(nnodes);

    logic [nworkers-1:0]       resp_val;
    logic [nworkers-1:0]       resp_rdy;
    logic [nworkers*iw-1:0]    resp_idx;
    logic [nworkers*nbits-1:0] resp_data;
    logic                      out_val;
    logic                      out_rdy;
    logic [iw-1:0]             out_idx;
    logic [nbits-1:0]          out_data;
    logic                      out_last;

    modport master (
        input  resp_val, resp_idx, resp_data, out_rdy,
        output resp_rdy, out_val, out_idx, out_data, out_last
    );

    modport slave (
        output resp_val, resp_idx, resp_data, out_rdy,
        input  resp_rdy, out_val, out_idx, out_data, out_last
    );

endinterface

// File: rtl/pagerank_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req; priority moves past the
// granted requester whenever en && |req.
module pagerank_rr_arbiter #(
    parameter int nworkers = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [nworkers-1:0] req,
    input  logic                en,
    output logic [nworkers-1:0] grant
);
    localparam int pw = (nworkers > 1) ? $clog2(nworkers) : 1;

    logic [pw-1:0] ptr_q;
    int            gidx;
    int            k;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        grant = '0;
        gidx  = 0;
        k     = 0;
        // Walk from lowest priority to highest so the highest-priority requester wins last.
        for (int i = nworkers - 1; i >= 0; i--) begin
            k = int'(ptr_q) + i;
            if (k >= nworkers) k = k - nworkers;
            if (en && req[k[pw-1:0]]) begin
                grant            = '0;
                grant[k[pw-1:0]] = 1'b1;
                gidx             = k;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (en && |req) begin
            ptr_q <= (gidx == nworkers - 1) ? '0 : pw'(gidx + 1);
        end
    end

endmodule

// File: rtl/pagerank_result_collector.sv
// Collects per-node rank results from worker PEs and streams the rebuilt
// vector in node order. Optional PR_COLLECT_PERF_EN adds the perf_stall counter.
module pagerank_result_collector
    import pagerank_pkg::*;
#(
    parameter int nbits    = NBITS,
    parameter int nworkers = NWORKERS,
    parameter int nnodes   = NNODES
) (
    input  logic                         clk,
    input  logic                         reset,
    pagerank_result_collector_if.master  bus,
    output logic                         dup_err,
    output logic [15:0]                  iter_count
`ifdef PR_COLLECT_PERF_EN
    ,
    output logic [31:0]                  perf_stall
`endif
);
    localparam int iw = $clog2(nnodes);

    collect_state_e      state_q, state_d;
    logic [nnodes-1:0]   valid_q;
    logic [nbits-1:0]    buffer_q [nnodes];
    logic [iw-1:0]       cnt_q;
    logic [15:0]         iter_q;
    logic                dup_q;

    logic                arb_en;
    logic [nworkers-1:0] grant;
    logic [iw-1:0]       sel_idx;
    logic [nbits-1:0]    sel_data;
    logic                accept;
    logic                is_dup;
    logic                completes;
    logic                out_hs;

    pagerank_rr_arbiter #(.nworkers(nworkers)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (bus.resp_val),
        .en    (arb_en),
        .grant (grant)
    );

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int w = 0; w < nworkers; w++) begin
            if (grant[w]) begin
                sel_idx  = bus.resp_idx[w*iw +: iw];
                sel_data = bus.resp_data[w*nbits +: nbits];
            end
        end
    end

    always_comb begin
        arb_en       = !reset && (state_q == COLLECT);
        accept       = |grant;
        is_dup       = valid_q[sel_idx];
        // The final result is the one whose write leaves every valid bit set.
        completes    = accept && !is_dup && (&(valid_q | (nnodes'(1) << sel_idx)));
        bus.resp_rdy = grant;
        bus.out_val  = !reset && (state_q == DRAIN);
        bus.out_idx  = cnt_q;
        bus.out_data = buffer_q[cnt_q];
        bus.out_last = bus.out_val && (cnt_q == iw'(nnodes - 1));
        out_hs       = bus.out_val && bus.out_rdy;

        state_d = state_q;
        case (state_q)
            COLLECT: if (completes)                 state_d = DRAIN;
            DRAIN:   if (out_hs && bus.out_last)    state_d = COLLECT;
            default:                                state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            valid_q <= '0;
            cnt_q   <= '0;
            iter_q  <= '0;
            dup_q   <= 1'b0;
            // NOTE: the buffer is a register array with a defined reset value, not a RAM macro.
            for (int n = 0; n < nnodes; n++) buffer_q[n] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (is_dup) begin
                    dup_q <= 1'b1;
                end else begin
                    buffer_q[sel_idx] <= sel_data;
                    valid_q[sel_idx]  <= 1'b1;
                end
            end
            if (out_hs) begin
                if (bus.out_last) begin
                    valid_q <= '0;
                    cnt_q   <= '0;
                    iter_q  <= iter_q + 16'd1;
                end else begin
                    cnt_q <= cnt_q + iw'(1);
                end
            end
        end
    end

    assign dup_err    = dup_q;
    assign iter_count = iter_q;

`ifdef PR_COLLECT_PERF_EN
    logic [31:0] stall_q;
    logic        stall_evt;

    always_comb begin
        stall_evt = 1'b0;
        if (!reset) begin
            if (state_q == COLLECT) stall_evt = |(bus.resp_val & ~grant);
            else                    stall_evt = |bus.resp_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)          stall_q <= '0;
        else if (stall_evt) stall_q <= sat_inc32(stall_q);
    end

    assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_pagerank_result_collector.sv
// Directed bench for pagerank_result_collector; define PR_COLLECT_PERF_EN to
// also exercise perf_stall.
module tb_pagerank_result_collector;
    import pagerank_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        dup_err;
    logic [15:0] iter_count;
`ifdef PR_COLLECT_PERF_EN
    logic [31:0] perf_stall;
`endif

    int vectors     = 0;
    int miscompares = 0;

    pagerank_result_collector_if #(.nbits(32), .nworkers(2), .nnodes(8)) bus ();

    pagerank_result_collector #(.nbits(32), .nworkers(2), .nnodes(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .dup_err    (dup_err),
        .iter_count (iter_count)
`ifdef PR_COLLECT_PERF_EN
        ,
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] v, input logic [2:0] i0, input logic [31:0] d0,
                         input logic [2:0] i1, input logic [31:0] d1);
        bus.resp_val  = v;
        bus.resp_idx  = {i1, i0};
        bus.resp_data = {d1, d0};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        bus.out_rdy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Worker 0 alone sends idx 0..7 with data base+idx; returns in DRAIN.
    task automatic fill_single(input int base);
        for (int i = 0; i < 8; i++) begin
            drive(2'b01, 3'(i), 32'(base + i), 3'd0, 32'd0);
            @(negedge clk);
        end
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.out_rdy = 1'b1;
        drive(2'b11, 3'd1, 32'd1, 3'd2, 32'd2);
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus.resp_rdy !== 2'b00) begin miscompares++; $display("FAIL reset_rdy got %b want 00", bus.resp_rdy); end
        vectors++; if (bus.out_val !== 1'b0) begin miscompares++; $display("FAIL reset_out_val got %b want 0", bus.out_val); end
        vectors++; if (bus.out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
        reset = 1'b0;
        bus.out_rdy = 1'b0;
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        @(negedge clk);
        vectors++; if (iter_count !== 16'd0) begin miscompares++; $display("FAIL reset_iter got %0d want 0", iter_count); end
        vectors++; if (dup_err !== 1'b0) begin miscompares++; $display("FAIL reset_dup got %b want 0", dup_err); end
        vectors++; if (bus.out_val !== 1'b0) begin miscompares++; $display("FAIL post_reset_out_val got %b want 0", bus.out_val); end
        drive(2'b11, 3'd0, 32'd0, 3'd1, 32'd0);
        #1;
        vectors++; if (bus.resp_rdy !== 2'b01) begin miscompares++; $display("FAIL reset_ptr_grant got %b want 01", bus.resp_rdy); end
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
    endtask

    task automatic test_single_worker();
        for (int i = 0; i < 8; i++) begin
            drive(2'b01, 3'(i), 32'(100 + i), 3'd0, 32'd0);
            #1;
            vectors++; if (bus.resp_rdy !== 2'b01) begin miscompares++; $display("FAIL single_rdy[%0d] got %b want 01", i, bus.resp_rdy); end
            @(negedge clk);
        end
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++; if (bus.out_val !== 1'b1) begin miscompares++; $display("FAIL single_out_val[%0d] got %b want 1", i, bus.out_val); end
            vectors++; if (bus.out_idx !== 3'(i)) begin miscompares++; $display("FAIL single_out_idx got %0d want %0d", bus.out_idx, i); end
            vectors++; if (bus.out_data !== 32'(100 + i)) begin miscompares++; $display("FAIL single_out_data[%0d] got %0d want %0d", i, bus.out_data, 100 + i); end
            vectors++; if (bus.out_last !== (i == 7)) begin miscompares++; $display("FAIL single_out_last[%0d] got %b want %b", i, bus.out_last, i == 7); end
            @(negedge clk);
        end
        bus.out_rdy = 1'b0;
        #1;
        vectors++; if (bus.out_val !== 1'b0) begin miscompares++; $display("FAIL single_done_val got %b want 0", bus.out_val); end
        vectors++; if (iter_count !== 16'd1) begin miscompares++; $display("FAIL single_iter got %0d want 1", iter_count); end
        vectors++; if (dup_err !== 1'b0) begin miscompares++; $display("FAIL single_dup got %b want 0", dup_err); end
        drive(2'b01, 3'd0, 32'd0, 3'd0, 32'd0);
        #1;
        vectors++; if (bus.resp_rdy !== 2'b01) begin miscompares++; $display("FAIL single_rearm_rdy got %b want 01", bus.resp_rdy); end
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
    endtask

    task automatic test_both_workers();
        int a0 = 0;
        int a1 = 0;
        logic [1:0] exp;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive({a1 < 4, a0 < 4}, 3'(2 * a0), 32'(200 + 2 * a0), 3'(2 * a1 + 1), 32'(201 + 2 * a1));
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            vectors++; if (bus.resp_rdy !== exp) begin miscompares++; $display("FAIL both_grant[%0d] got %b want %b", k, bus.resp_rdy, exp); end
            if (exp[0]) a0++; else a1++;
            @(negedge clk);
        end
        drive(2'b11, 3'd0, 32'd0, 3'd1, 32'd0);
        #1;
        vectors++; if (bus.out_val !== 1'b1) begin miscompares++; $display("FAIL both_out_val_cycle9 got %b want 1", bus.out_val); end
        vectors++; if (bus.resp_rdy !== 2'b00) begin miscompares++; $display("FAIL both_drain_rdy got %b want 00", bus.resp_rdy); end
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++; if (bus.out_data !== 32'(200 + i)) begin miscompares++; $display("FAIL both_out_data[%0d] got %0d want %0d", i, bus.out_data, 200 + i); end
            @(negedge clk);
        end
        bus.out_rdy = 1'b0;
        vectors++; if (iter_count !== 16'd1) begin miscompares++; $display("FAIL both_iter got %0d want 1", iter_count); end
    endtask

    task automatic test_dup();
        for (int i = 0; i < 8; i++) begin
            drive(2'b01, 3'(i), (i == 3) ? 32'd5 : 32'(300 + i), 3'd0, 32'd0);
            @(negedge clk);
            if (i == 3) begin
                vectors++; if (dup_err !== 1'b0) begin miscompares++; $display("FAIL dup_pre got %b want 0", dup_err); end
                drive(2'b10, 3'd0, 32'd0, 3'd3, 32'hDEAD);
                #1;
                vectors++; if (bus.resp_rdy !== 2'b10) begin miscompares++; $display("FAIL dup_consumed got %b want 10", bus.resp_rdy); end
                @(negedge clk);
                vectors++; if (dup_err !== 1'b1) begin miscompares++; $display("FAIL dup_set got %b want 1", dup_err); end
                vectors++; if (bus.out_val !== 1'b0) begin miscompares++; $display("FAIL dup_no_drain got %b want 0", bus.out_val); end
            end
        end
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++; if (bus.out_data !== ((i == 3) ? 32'd5 : 32'(300 + i))) begin miscompares++; $display("FAIL dup_out_data[%0d] got %0h want %0h", i, bus.out_data, (i == 3) ? 5 : 300 + i); end
            @(negedge clk);
        end
        bus.out_rdy = 1'b0;
        vectors++; if (dup_err !== 1'b1) begin miscompares++; $display("FAIL dup_sticky got %b want 1", dup_err); end
        vectors++; if (iter_count !== 16'd2) begin miscompares++; $display("FAIL dup_iter got %0d want 2", iter_count); end
    endtask

    task automatic test_drain_stall();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int exp = 0;
        fill_single(400);
        drive(2'b11, 3'd0, 32'd0, 3'd1, 32'd0);
        for (int c = 0; c < 40 && exp < 8; c++) begin
            bus.out_rdy = pat[c % 4];
            #1;
            vectors++; if (bus.out_val !== 1'b1) begin miscompares++; $display("FAIL stall_out_val[%0d] got %b want 1", c, bus.out_val); end
            vectors++; if (bus.resp_rdy !== 2'b00) begin miscompares++; $display("FAIL stall_resp_rdy[%0d] got %b want 00", c, bus.resp_rdy); end
            vectors++; if (bus.out_idx !== 3'(exp)) begin miscompares++; $display("FAIL stall_out_idx[%0d] got %0d want %0d", c, bus.out_idx, exp); end
            vectors++; if (bus.out_data !== 32'(400 + exp)) begin miscompares++; $display("FAIL stall_out_data[%0d] got %0d want %0d", c, bus.out_data, 400 + exp); end
            if (bus.out_rdy) exp++;
            @(negedge clk);
        end
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        bus.out_rdy = 1'b0;
        vectors++; if (exp != 8) begin miscompares++; $display("FAIL stall_timeout got %0d entries want 8", exp); end
        vectors++; if (iter_count !== 16'd3) begin miscompares++; $display("FAIL stall_iter got %0d want 3", iter_count); end
    endtask

    task automatic test_reset_mid_drain();
        fill_single(500);
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if (bus.out_val !== 1'b0) begin miscompares++; $display("FAIL mid_reset_val got %b want 0", bus.out_val); end
        @(negedge clk);
        reset = 1'b0;
        bus.out_rdy = 1'b0;
        #1;
        vectors++; if (bus.out_val !== 1'b0) begin miscompares++; $display("FAIL after_reset_val got %b want 0", bus.out_val); end
        vectors++; if (iter_count !== 16'd0) begin miscompares++; $display("FAIL after_reset_iter got %0d want 0", iter_count); end
        vectors++; if (dup_err !== 1'b0) begin miscompares++; $display("FAIL after_reset_dup got %b want 0", dup_err); end
        for (int i = 7; i >= 0; i--) begin
            drive(2'b01, 3'(i), 32'(600 + i), 3'd0, 32'd0);
            @(negedge clk);
        end
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++; if (bus.out_idx !== 3'(i)) begin miscompares++; $display("FAIL fresh_out_idx got %0d want %0d", bus.out_idx, i); end
            vectors++; if (bus.out_data !== 32'(600 + i)) begin miscompares++; $display("FAIL fresh_out_data[%0d] got %0d want %0d", i, bus.out_data, 600 + i); end
            @(negedge clk);
        end
        bus.out_rdy = 1'b0;
        vectors++; if (iter_count !== 16'd1) begin miscompares++; $display("FAIL fresh_iter got %0d want 1", iter_count); end
    endtask

`ifdef PR_COLLECT_PERF_EN
    task automatic test_perf();
        int a0 = 0;
        int a1 = 0;
        do_reset();
        @(negedge clk);
        vectors++; if (perf_stall !== 32'd0) begin miscompares++; $display("FAIL perf_reset got %0d want 0", perf_stall); end
        for (int k = 0; k < 8; k++) begin
            drive({a1 < 4, 1'b1}, (a0 < 4) ? 3'(2 * a0) : 3'd0, 32'(700 + k), 3'(2 * a1 + 1), 32'(800 + k));
            if (k % 2 == 0) a0++; else a1++;
            @(negedge clk);
        end
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        #1;
        vectors++; if (perf_stall !== 32'd8) begin miscompares++; $display("FAIL perf_collect got %0d want 8", perf_stall); end
        drive(2'b01, 3'd0, 32'd0, 3'd0, 32'd0);
        @(negedge clk);
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        vectors++; if (perf_stall !== 32'd9) begin miscompares++; $display("FAIL perf_drain got %0d want 9", perf_stall); end
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clk);
        bus.out_rdy = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.out_rdy = 1'b0;
        drive(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
        @(negedge clk);
        test_reset();
        test_single_worker();
        test_both_workers();
        test_dup();
        test_drain_stall();
        test_reset_mid_drain();
`ifdef PR_COLLECT_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
